game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Top-level play-state sequencer, directly downstream of the enemy block.
- Consumes the enemy's latched collides flag and relative enemy Y, plus Mario position/velocity; decides stomp vs. death, tracks lives, level completion and pit falls.
- Produces the 2-bit state bus the enemy and Mario blocks use to reset/hold their positions (anything other than PLAY resets the enemy).
- One update per frame_clk edge.

Parameters:
- LIVES_INIT, 3, lives loaded at reset and on return to TITLE (3-bit)
- DEATH_FRAMES, 120, frames spent in DYING before respawn/game over
- PIT_Y, 470, Mario Y at/above which he is considered fallen in a pit
- FLAG_X, 3168, global X (Mario X + background_offset) at/above which level is won
- STOMP_MARGIN, 8, Mario bottom (Y+16) must be <= enemy Y - 16 + STOMP_MARGIN for a stomp
- INV_FRAMES, 60, post-respawn invincibility length (optional feature only)

Ports:
- frame_clk  in  1  frame clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high
- start  in  1  start/confirm key, level signal
- Ball_X_Pos  in  18  Mario screen X
- Ball_Y_Pos  in  18  Mario Y
- background_offset  in  18  scroll offset; global X = Ball_X_Pos + background_offset
- mario_falling  in  1  1 when Mario vertical velocity is downward
- enemy1_collides  in  1  enemy block's latched contact flag
- enemy1_Y_Pos_rel  in  18  enemy Y
- state  out  2  00 TITLE, 01 PLAY, 10 DYING, 11 END
- lives  out  3  remaining lives
- enemy1_dead  out  1  enemy has been stomped; renderer hides it, contacts ignored
- win  out  1  valid in END: 1 = flag reached, 0 = game over

Behaviour:
- Reset (async): state=TITLE, lives=LIVES_INIT, enemy1_dead=0, win=0, death timer=0, edge registers=0.
- Edge detection: start_prev and coll_prev registered each frame. start_rise = start & ~start_prev; coll_rise = enemy1_collides & ~coll_prev. coll_prev is forced to 0 whenever state != PLAY. The enemy's collides flag is sticky, so only the rising edge acts.
- Stomp = coll_rise & mario_falling & (Ball_Y_Pos + 16 <= enemy1_Y_Pos_rel - 16 + STOMP_MARGIN). All comparisons are 18-bit unsigned.
- TITLE: start_rise -> PLAY. Clears enemy1_dead and win.
- PLAY, with per-frame priority high to low:
  - global X >= FLAG_X -> END, win=1.
  - Ball_Y_Pos >= PIT_Y -> DYING, lives-1.
  - Stomp with enemy1_dead=0 -> enemy1_dead=1, stay in PLAY.
  - coll_rise with enemy1_dead=0 and not a stomp -> DYING, lives-1.
  - Otherwise stay in PLAY.
- On entry to DYING, the timer loads DEATH_FRAMES-1.
- DYING: timer decrements each frame. At timer==0:
  - lives==0 -> END, win=0.
  - Otherwise -> PLAY with enemy1_dead=0 (enemy respawns because it was held in reset during DYING).
- END: start_rise -> TITLE, lives=LIVES_INIT. All other inputs are ignored.
- lives saturates at 0 and never wraps; a decrement from 0 is impossible by construction but the RTL still guards it.
- start held continuously does not chain transitions; a new press is required.
- Outputs are registered with one-frame latency from the causing input.
- Reset mid-DYING or mid-END returns to TITLE immediately and discards the timer.

Optional Feature:
- Macro RESPAWN_INVINCIBILITY_EN.
- Defined: on DYING->PLAY and TITLE->PLAY, a second frame_timer loads INV_FRAMES-1. While it is nonzero, non-stomp coll_rise is ignored. Stomps and pit deaths still apply.
- Undefined: no invincibility timer exists; behaviour is exactly as above.

Decomposition:
- Shared package game_pkg holds: typedef enum logic [1:0] game_state_t {TITLE, PLAY, DYING, END}; constants SPRITE_HALF=16, PIT_Y, FLAG_X.
- The enemy and Mario blocks also import game_state_t.
- Sub-module frame_timer: loadable down-counter with load, load_val, en, zero flag. Instantiated once for the death timer and once more under RESPAWN_INVINCIBILITY_EN.

Test Plan:
- Reset, then pulse start for 1 frame -> state 00 to 01 next frame, lives=3; hold start 10 frames -> no further transitions.
- In PLAY, raise enemy1_collides with mario_falling=0, Ball_Y=408, enemy Y=408 -> state=10, lives=2; after 120 frames -> state=01.
- In PLAY, Ball_Y=376, enemy Y=408, mario_falling=1, raise collides -> enemy1_dead=1, state stays 01; later non-stomp contact -> ignored.
- lives=1, Ball_Y_Pos=470 -> DYING, lives=0; after 120 frames -> state=11, win=0; start pulse -> TITLE, lives=3.
- Same frame: Ball_X+offset=3168 and Ball_Y=470 -> END with win=1 (flag priority).
- With RESPAWN_INVINCIBILITY_EN: contact 30 frames after respawn -> no death; contact at frame 61 -> DYING.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared play-state type and playfield constants
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        DYING = 2'b10,
        END   = 2'b11
    } game_state_t;

    localparam logic [17:0] SPRITE_HALF = 18'd16;
    localparam logic [17:0] PIT_Y       = 18'd470;
    localparam logic [17:0] FLAG_X      = 18'd3168;

endpackage

// File: rtl/game_state_ctrl_if.sv
// rtl/game_state_ctrl_if.sv - Mario/enemy inputs and play-state outputs of the sequencer
interface game_state_ctrl_if;
    import game_pkg::*;

    logic          start;
    logic [17:0]   Ball_X_Pos;
    logic [17:0]   Ball_Y_Pos;
    logic [17:0]   background_offset;
    logic          mario_falling;
    logic          enemy1_collides;
    logic [17:0]   enemy1_Y_Pos_rel;
    game_state_t   state;
    logic [2:0]    lives;
    logic          enemy1_dead;
    logic          win;

    modport master (
        output start, Ball_X_Pos, Ball_Y_Pos, background_offset,
               mario_falling, enemy1_collides, enemy1_Y_Pos_rel,
        input  state, lives, enemy1_dead, win
    );

    modport slave (
        input  start, Ball_X_Pos, Ball_Y_Pos, background_offset,
               mario_falling, enemy1_collides, enemy1_Y_Pos_rel,
        output state, lives, enemy1_dead, win
    );

endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable per-frame down-counter with zero flag; load wins over decrement
module frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - play-state sequencer: stomp/death, lives, flag and pit handling.
// Optional RESPAWN_INVINCIBILITY_EN adds a post-spawn window where enemy contact is ignored.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_FRAMES = 120,
    parameter int STOMP_MARGIN = 8,
    parameter int INV_FRAMES   = 60
) (
    input  logic                frame_clk,
    input  logic                Reset,
    game_state_ctrl_if.slave    bus
);

    localparam int TW = 8;

    game_state_t state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic        enemy1_dead_q, enemy1_dead_d;
    logic        win_q, win_d;
    logic        start_prev_q, start_prev_d;
    logic        coll_prev_q, coll_prev_d;

    logic        start_rise, coll_rise, stomp, hit;
    logic [17:0] global_x, mario_bottom, stomp_line;
    logic [2:0]  lives_dec;
    logic        death_load, death_zero;
    logic        inv_load, inv_active;

    assign global_x     = bus.Ball_X_Pos + bus.background_offset;
    assign mario_bottom = bus.Ball_Y_Pos + SPRITE_HALF;
    assign stomp_line   = bus.enemy1_Y_Pos_rel - SPRITE_HALF + 18'(STOMP_MARGIN);
    assign start_rise   = bus.start & ~start_prev_q;
    assign coll_rise    = bus.enemy1_collides & ~coll_prev_q;
    assign stomp        = coll_rise & bus.mario_falling & (mario_bottom <= stomp_line);
    assign hit          = coll_rise & ~stomp & ~inv_active;
    assign lives_dec    = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        enemy1_dead_d = enemy1_dead_q;
        win_d         = win_q;
        death_load    = 1'b0;
        inv_load      = 1'b0;
        start_prev_d  = bus.start;
        // The enemy's contact flag is sticky; outside PLAY it is cleared so a fresh contact re-arms.
        coll_prev_d   = (state_q == PLAY) ? bus.enemy1_collides : 1'b0;

        case (state_q)
            TITLE: begin
                if (start_rise) begin
                    state_d       = PLAY;
                    enemy1_dead_d = 1'b0;
                    win_d         = 1'b0;
                    inv_load      = 1'b1;
                end
            end
            PLAY: begin
                if (global_x >= FLAG_X) begin
                    state_d = END;
                    win_d   = 1'b1;
                end else if (bus.Ball_Y_Pos >= PIT_Y) begin
                    state_d    = DYING;
                    lives_d    = lives_dec;
                    death_load = 1'b1;
                end else if (stomp && !enemy1_dead_q) begin
                    enemy1_dead_d = 1'b1;
                end else if (hit && !enemy1_dead_q) begin
                    state_d    = DYING;
                    lives_d    = lives_dec;
                    death_load = 1'b1;
                end
            end
            DYING: begin
                if (death_zero) begin
                    if (lives_q == 3'd0) begin
                        state_d = END;
                        win_d   = 1'b0;
                    end else begin
                        state_d       = PLAY;
                        enemy1_dead_d = 1'b0;
                        inv_load      = 1'b1;
                    end
                end
            end
            END: begin
                if (start_rise) begin
                    state_d = TITLE;
                    lives_d = 3'(LIVES_INIT);
                end
            end
            default: state_d = TITLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= TITLE;
            lives_q       <= 3'(LIVES_INIT);
            enemy1_dead_q <= 1'b0;
            win_q         <= 1'b0;
            start_prev_q  <= 1'b0;
            coll_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            enemy1_dead_q <= enemy1_dead_d;
            win_q         <= win_d;
            start_prev_q  <= start_prev_d;
            coll_prev_q   <= coll_prev_d;
        end
    end

    frame_timer #(.WIDTH(TW)) u_death_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (death_load),
        .load_val  (TW'(DEATH_FRAMES - 1)),
        .en        (state_q == DYING),
        .zero      (death_zero)
    );

`ifdef RESPAWN_INVINCIBILITY_EN
    logic inv_zero;

    frame_timer #(.WIDTH(TW)) u_inv_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (inv_load),
        .load_val  (TW'(INV_FRAMES - 1)),
        .en        (1'b1),
        .zero      (inv_zero)
    );

    assign inv_active = ~inv_zero;
`else
    logic unused_inv;
    assign unused_inv = inv_load;
    assign inv_active = 1'b0;
`endif

    assign bus.state       = state_q;
    assign bus.lives       = lives_q;
    assign bus.enemy1_dead = enemy1_dead_q;
    assign bus.win         = win_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed bench with a rule-level play-state model checked every frame
module tb_game_state_ctrl;

    logic frame_clk;
    logic Reset;
    int   total;
    int   bad;

    game_state_ctrl_if bus ();

    game_state_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    // Model: 0 title, 1 play, 2 dying, 3 end; dying_left counts frames still to spend dying.
    int m_state, m_lives, m_dead, m_win, m_left, m_sprev, m_cprev;

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_dead = 0; m_win = 0;
        m_left = 0; m_sprev = 0; m_cprev = 0;
    endtask

    task automatic model_update();
        int gx, bottom, line, s_rise, c_rise, is_stomp;
        gx       = (int'(bus.Ball_X_Pos) + int'(bus.background_offset)) % 262144;
        bottom   = (int'(bus.Ball_Y_Pos) + 16) % 262144;
        line     = (int'(bus.enemy1_Y_Pos_rel) + 262144 - 8) % 262144;
        s_rise   = (bus.start && m_sprev == 0) ? 1 : 0;
        c_rise   = (bus.enemy1_collides && m_cprev == 0) ? 1 : 0;
        is_stomp = (c_rise == 1 && bus.mario_falling && bottom <= line) ? 1 : 0;
        m_sprev  = bus.start ? 1 : 0;
        m_cprev  = (m_state == 1 && bus.enemy1_collides) ? 1 : 0;
        case (m_state)
            0: if (s_rise == 1) begin m_state = 1; m_dead = 0; m_win = 0; end
            1: begin
                if (gx >= 3168) begin
                    m_state = 3; m_win = 1;
                end else if (int'(bus.Ball_Y_Pos) >= 470) begin
                    m_state = 2; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_left = 120;
                end else if (c_rise == 1 && m_dead == 0 && is_stomp == 1) begin
                    m_dead = 1;
                end else if (c_rise == 1 && m_dead == 0) begin
                    m_state = 2; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_left = 120;
                end
            end
            2: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_lives == 0) begin m_state = 3; m_win = 0; end
                    else begin m_state = 1; m_dead = 0; end
                end
            end
            default: if (s_rise == 1) begin m_state = 0; m_lives = 3; end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("state", int'(bus.state), m_state);
        chk("lives", int'(bus.lives), m_lives);
        chk("enemy1_dead", int'(bus.enemy1_dead), m_dead);
        chk("win", int'(bus.win), m_win);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_update();
        @(negedge frame_clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        bus.start = 1'b0;
        bus.Ball_X_Pos = 18'd100;
        bus.Ball_Y_Pos = 18'd408;
        bus.background_offset = 18'd0;
        bus.mario_falling = 1'b0;
        bus.enemy1_collides = 1'b0;
        bus.enemy1_Y_Pos_rel = 18'd408;
        model_reset();
        repeat (2) @(negedge frame_clk);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_lives", int'(bus.lives), 3);
        chk("reset_dead", int'(bus.enemy1_dead), 0);
        chk("reset_win", int'(bus.win), 0);
        Reset = 1'b0;
        ticks(2);

        // Start pulse, then held start must not chain transitions
        bus.start = 1'b1; tick();
        chk("start_to_play", int'(bus.state), 1);
        chk("play_lives", int'(bus.lives), 3);
        ticks(10);
        chk("held_start_no_chain", int'(bus.state), 1);
        bus.start = 1'b0; tick();

        // Side contact: death, 120 frames in DYING, respawn
        bus.enemy1_collides = 1'b1; tick();
        chk("contact_dying", int'(bus.state), 2);
        chk("contact_lives", int'(bus.lives), 2);
        bus.enemy1_collides = 1'b0;
        ticks(119);
        chk("still_dying_119", int'(bus.state), 2);
        tick();
        chk("respawn_play", int'(bus.state), 1);

        // Stomp, then a later side contact is ignored
        bus.Ball_Y_Pos = 18'd376; bus.mario_falling = 1'b1; bus.enemy1_collides = 1'b1; tick();
        chk("stomp_dead", int'(bus.enemy1_dead), 1);
        chk("stomp_stay_play", int'(bus.state), 1);
        bus.enemy1_collides = 1'b0; bus.mario_falling = 1'b0; bus.Ball_Y_Pos = 18'd408; tick();
        bus.enemy1_collides = 1'b1; tick();
        chk("dead_enemy_ignored", int'(bus.state), 1);
        bus.enemy1_collides = 1'b0; tick();

        // Pit deaths down to game over
        bus.Ball_Y_Pos = 18'd470; tick();
        chk("pit_lives1", int'(bus.lives), 1);
        bus.Ball_Y_Pos = 18'd408; ticks(120);
        chk("pit_respawn_alive", int'(bus.enemy1_dead), 0);
        bus.Ball_Y_Pos = 18'd470; tick();
        chk("pit_lives0", int'(bus.lives), 0);
        bus.Ball_Y_Pos = 18'd408; ticks(120);
        chk("game_over_state", int'(bus.state), 3);
        chk("game_over_win", int'(bus.win), 0);
        bus.enemy1_collides = 1'b1; bus.Ball_Y_Pos = 18'd470; tick();
        chk("end_ignores", int'(bus.state), 3);
        bus.enemy1_collides = 1'b0; bus.Ball_Y_Pos = 18'd408;
        bus.start = 1'b1; tick();
        chk("end_to_title", int'(bus.state), 0);
        chk("title_lives", int'(bus.lives), 3);
        bus.start = 1'b0; tick();

        // Flag boundary and flag-over-pit priority
        pulse_start();
        bus.Ball_X_Pos = 18'd3000; bus.background_offset = 18'd167; bus.Ball_Y_Pos = 18'd469; tick();
        chk("flag_minus1", int'(bus.state), 1);
        bus.background_offset = 18'd168; bus.Ball_Y_Pos = 18'd470; tick();
        chk("flag_state", int'(bus.state), 3);
        chk("flag_win", int'(bus.win), 1);
        chk("flag_lives", int'(bus.lives), 3);
        bus.Ball_X_Pos = 18'd100; bus.background_offset = 18'd0; bus.Ball_Y_Pos = 18'd408;

        // Asynchronous reset in the middle of DYING
        pulse_start();
        pulse_start();
        bus.Ball_Y_Pos = 18'd470; tick();
        bus.Ball_Y_Pos = 18'd408; ticks(10);
        #2 Reset = 1'b1;
        #1 chk("async_reset_state", int'(bus.state), 0);
        chk("async_reset_lives", int'(bus.lives), 3);
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
        compare();

        // Stomp margin boundary: one pixel too low dies, exact limit stomps
        pulse_start();
        bus.Ball_Y_Pos = 18'd385; bus.mario_falling = 1'b1; bus.enemy1_collides = 1'b1; tick();
        chk("margin_plus1_dies", int'(bus.state), 2);
        bus.enemy1_collides = 1'b0; bus.mario_falling = 1'b0; bus.Ball_Y_Pos = 18'd408;
        ticks(120);
        bus.Ball_Y_Pos = 18'd384; bus.mario_falling = 1'b1; bus.enemy1_collides = 1'b1; tick();
        chk("margin_exact_stomp", int'(bus.enemy1_dead), 1);
        bus.enemy1_collides = 1'b0; bus.mario_falling = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
